// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
//
// Write-side control of the asynchronous FIFO. It sits directly in front of
// the dual-port RAM write port (port 0). It accepts write requests in the
// clk_0 domain and produces the RAM write address and write strobe. It brings
// the read side's Gray pointer into this domain through a 2-flop
// synchroniser, keeps the full flag and a conservative fill level, and
// exports its own registered Gray write pointer to the read side.
//
// Optional feature macro: FIFO_WR_ALMOST_FULL_EN
//   defined   : almost_full is registered, level >= ALMOST_FULL_THRESH
//   undefined : almost_full is tied low and no comparator exists
//
// Ports
//   clk_0            in   write-domain clock (same net as RAM clk_0)
//   rst_0            in   synchronous, active-high reset
//   wr_en            in   write request for this cycle
//   rptr_gray_async  in   read pointer, Gray coded, unsynchronised [AW:0]
//   waddr            out  RAM write address (addr_0) [AW-1:0]
//   ram_we           out  RAM write strobe (we_0 and oe_0)
//   wptr_gray        out  registered Gray write pointer [AW:0]
//   full             out  registered full flag
//   wr_level         out  registered, pessimistic fill count [AW:0]
//   wr_overflow      out  one-cycle pulse: write requested while full
//   almost_full      out  level >= ALMOST_FULL_THRESH (optional)
// -----------------------------------------------------------------------------
module fifo_wr_ctrl #(
   parameter int ADDR_WIDTH         = 4,
   parameter int DATA_DEPTH         = 1 << ADDR_WIDTH,
   parameter int ALMOST_FULL_THRESH = DATA_DEPTH - 2
) (
   input  logic                  clk_0,
   input  logic                  rst_0,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH:0]   rptr_gray_async,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic                  ram_we,
   output logic [ADDR_WIDTH:0]   wptr_gray,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   wr_level,
   output logic                  wr_overflow,
   output logic                  almost_full
);

   // Pointer width: one extra bit distinguishes full from empty.
   localparam int PW = ADDR_WIDTH + 1;

   // Elaboration-time parameter sanity checks.
   if (ADDR_WIDTH < 2) begin : g_chk_aw
      $error("fifo_wr_ctrl: ADDR_WIDTH must be at least 2");
   end
   if (DATA_DEPTH != (1 << ADDR_WIDTH)) begin : g_chk_depth
      $error("fifo_wr_ctrl: DATA_DEPTH must equal 1 << ADDR_WIDTH");
   end

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [PW-1:0] r_wbin;        // binary write pointer
   logic [PW-1:0] r_wptr_gray;   // Gray copy of r_wbin, exported
   logic [PW-1:0] r_rq1;         // synchroniser stage 1 (may go metastable)
   logic [PW-1:0] r_rq2;         // synchroniser stage 2 (safe to use)
   logic          r_full;
   logic [PW-1:0] r_level;
   logic          r_overflow;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   logic          w_accept;
   logic [PW-1:0] w_wbin_next;
   logic [PW-1:0] w_wgray_next;
   logic [PW-1:0] w_rbin_sync;
   logic [PW-1:0] w_full_match;
   logic          w_full_next;
   logic [PW-1:0] w_level_next;
   logic          w_overflow_next;

   // A write is taken only while not full; a request against a full FIFO is
   // dropped and reported through wr_overflow instead.
   assign w_accept     = wr_en & ~r_full;
   assign w_wbin_next  = r_wbin + PW'(w_accept);
   assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      w_rbin_sync = '0;
      for (int i = 0; i < PW; i++) begin
         w_rbin_sync[i] = ^(r_rq2 >> i);
      end
   end

   // Full when the write pointer is exactly one lap ahead of the read pointer.
   // In Gray code that is the read pointer with its top two bits inverted.
   assign w_full_match = {~r_rq2[PW-1:PW-2], r_rq2[PW-3:0]};
   assign w_full_next  = (w_wgray_next == w_full_match);

   // Level uses the synchronised (stale) read pointer, so it can only
   // over-report occupancy, never under-report it.
   assign w_level_next    = w_wbin_next - w_rbin_sync;
   assign w_overflow_next = wr_en & r_full;

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_0) begin
      if (rst_0) begin
         r_wbin      <= '0;
         r_wptr_gray <= '0;
         r_rq1       <= '0;
         r_rq2       <= '0;
         r_full      <= 1'b0;
         r_level     <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_wbin      <= w_wbin_next;
         r_wptr_gray <= w_wgray_next;
         r_rq1       <= rptr_gray_async;
         r_rq2       <= r_rq1;
         r_full      <= w_full_next;
         r_level     <= w_level_next;
         r_overflow  <= w_overflow_next;
      end
   end

`ifdef FIFO_WR_ALMOST_FULL_EN
   // Threshold registered alongside full so both flags share the same latency.
   localparam logic [PW-1:0] AF_THRESH = PW'(ALMOST_FULL_THRESH);

   logic r_almost_full;

   always_ff @(posedge clk_0) begin
      if (rst_0) begin
         r_almost_full <= 1'b0;
      end else begin
         r_almost_full <= (w_level_next >= AF_THRESH);
      end
   end

   assign almost_full = r_almost_full;
`else
   assign almost_full = 1'b0;
`endif

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign ram_we      = w_accept;
   assign waddr       = r_wbin[PW-2:0];
   assign wptr_gray   = r_wptr_gray;
   assign full        = r_full;
   assign wr_level    = r_level;
   assign wr_overflow = r_overflow;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl
//
// Directed bench for fifo_wr_ctrl with ADDR_WIDTH=4 (16 entries). Inputs are
// driven 2 time units after the rising edge; outputs are sampled at that
// point (registered ones) or 1 unit later (combinational ram_we).
// -----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

   localparam int AW = 4;

   logic          clk_0;
   logic          rst_0;
   logic          wr_en;
   logic [AW:0]   rptr_gray_async;
   logic [AW-1:0] waddr;
   logic          ram_we;
   logic [AW:0]   wptr_gray;
   logic          full;
   logic [AW:0]   wr_level;
   logic          wr_overflow;
   logic          almost_full;

   int n_chk  = 0;
   int n_fail = 0;

   fifo_wr_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk_0           (clk_0),
      .rst_0           (rst_0),
      .wr_en           (wr_en),
      .rptr_gray_async (rptr_gray_async),
      .waddr           (waddr),
      .ram_we          (ram_we),
      .wptr_gray       (wptr_gray),
      .full            (full),
      .wr_level        (wr_level),
      .wr_overflow     (wr_overflow),
      .almost_full     (almost_full)
   );

   initial clk_0 = 1'b0;
   always #5 clk_0 = ~clk_0;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_0);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW:0] gray(input int b);
      logic [AW:0] v;
      v = AW'(0) + (AW+1)'(b);
      return v ^ (v >> 1);
   endfunction

   function automatic logic exp_af(input int lvl);
`ifdef FIFO_WR_ALMOST_FULL_EN
      return (lvl >= 14);
`else
      return 1'b0;
`endif
   endfunction

   logic [AW:0] hist [0:39];
   logic [AW:0] prev_g;
   int          b;
   int          lvl;

   initial begin
      rst_0           = 1'b1;
      wr_en           = 1'b1;
      rptr_gray_async = '0;

      // ---- reset: two edges with a write request that must be ignored ----
      tick();
      tick();
      rst_0 = 1'b0;
      wr_en = 1'b0;
      #1;
      chk("rst_waddr",  waddr,       0);
      chk("rst_wgray",  wptr_gray,   0);
      chk("rst_full",   full,        0);
      chk("rst_level",  wr_level,    0);
      chk("rst_ovf",    wr_overflow, 0);
      chk("rst_ram_we", ram_we,      0);
      chk("rst_afull",  almost_full, 0);

      // ---- fill: 16 writes with the read pointer held at 0 ----
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1;
         #1;
         chk($sformatf("fill_waddr_%0d", i), waddr,  i);
         chk($sformatf("fill_we_%0d", i),    ram_we, 1);
         tick();
         chk($sformatf("fill_level_%0d", i), wr_level, i + 1);
         chk($sformatf("fill_full_%0d", i),  full, (i == 15) ? 1 : 0);
         chk($sformatf("fill_afull_%0d", i), almost_full, exp_af(i + 1));
      end
      chk("fill_wgray", wptr_gray, 5'b11000);
      chk("fill_waddr", waddr,     0);

      // ---- overflow: one write against a full FIFO ----
      wr_en = 1'b1;
      #1;
      chk("ovf_ram_we", ram_we, 0);
      tick();
      wr_en = 1'b0;
      chk("ovf_pulse", wr_overflow, 1);
      chk("ovf_waddr", waddr,       0);
      chk("ovf_wgray", wptr_gray,   5'b11000);
      chk("ovf_level", wr_level,    16);
      chk("ovf_full",  full,        1);
      tick();
      chk("ovf_clear", wr_overflow, 0);

      // ---- drain: read side consumes one entry; seen on the 3rd edge ----
      rptr_gray_async = 5'b00001;
      tick();
      chk("drain_full_e1", full, 1);
      tick();
      chk("drain_full_e2", full, 1);
      tick();
      chk("drain_full_e3",  full,     0);
      chk("drain_level_e3", wr_level, 15);
      chk("drain_afull",    almost_full, exp_af(15));

      // ---- refill the freed slot, then reset with a write pending ----
      wr_en = 1'b1;
      #1;
      chk("refill_we",    ram_we, 1);
      chk("refill_waddr", waddr,  0);
      tick();
      chk("refill_full",  full,      1);
      chk("refill_level", wr_level,  16);
      chk("refill_wgray", wptr_gray, 5'b11001);
      rst_0           = 1'b1;
      rptr_gray_async = '0;
      tick();
      rst_0 = 1'b0;
      wr_en = 1'b0;
      chk("midrst_ovf",   wr_overflow, 0);
      chk("midrst_full",  full,        0);
      chk("midrst_wgray", wptr_gray,   0);
      chk("midrst_level", wr_level,    0);
      chk("midrst_waddr", waddr,       0);

      // ---- wrap: 40 writes, read pointer trails the write pointer by 4 ----
      for (int k = 0; k < 40; k++) begin
         hist[k]         = wptr_gray;
         rptr_gray_async = (k >= 4) ? hist[k-4] : '0;
         wr_en           = 1'b1;
         prev_g          = wptr_gray;
         tick();
         b   = (k + 1) % 32;
         lvl = (k + 1 < 7) ? k + 1 : 7;
         chk($sformatf("wrap_full_%0d", k),  full, 0);
         chk($sformatf("wrap_wgray_%0d", k), wptr_gray, gray(b));
         chk($sformatf("wrap_onebit_%0d", k), $countones(prev_g ^ wptr_gray), 1);
         chk($sformatf("wrap_waddr_%0d", k), waddr, b % 16);
         chk($sformatf("wrap_level_%0d", k), wr_level, lvl);
         if (k == 31) begin
            chk("wrap_31_to_0_prev", prev_g,    5'b10000);
            chk("wrap_31_to_0_now",  wptr_gray, 5'b00000);
         end
      end
      wr_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side control stage of the asynchronous FIFO, sitting directly upstream of the dual-port RAM's write port (port 0). It accepts write requests in the write clock domain and generates the RAM write address and write strobe. It synchronises the read side's Gray-coded pointer into the write domain, maintains the full flag and fill level, and exports its own Gray-coded write pointer for synchronisation by the read side.

## Interface
Parameters:
- ADDR_WIDTH, 4, RAM address width; minimum 2. Pointers are ADDR_WIDTH+1 bits.
- DATA_DEPTH, 1 << ADDR_WIDTH, FIFO capacity in entries; no other value is supported.
- ALMOST_FULL_THRESH, DATA_DEPTH-2, fill level at or above which almost_full asserts.

Ports:
- clk_0  in  1  write-domain clock; same net as RAM clk_0.
- rst_0  in  1  reset; synchronous, active-high.
- wr_en  in  1  write request for this cycle.
- rptr_gray_async  in  ADDR_WIDTH+1  read pointer, Gray code, from the read domain (unsynchronised).
- waddr  out  ADDR_WIDTH  RAM write address; drives addr_0.
- ram_we  out  1  RAM write strobe; drives both we_0 and oe_0.
- wptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, exported to the read domain.
- full  out  1  FIFO full, registered.
- wr_level  out  ADDR_WIDTH+1  conservative fill count, registered.
- wr_overflow  out  1  one-cycle pulse: write requested while full, dropped.
- almost_full  out  1  level >= ALMOST_FULL_THRESH (see Configuration).

## Operation
- State: binary write pointer wbin[ADDR_WIDTH:0], Gray register wptr_gray, and a 2-flop synchroniser rq1 -> rq2 on rptr_gray_async.
- ram_we = wr_en & ~full (combinational). waddr = wbin[ADDR_WIDTH-1:0].
- Accepted write: wbin_next = wbin + 1, modulo 2^(ADDR_WIDTH+1). wgray_next = wbin_next ^ (wbin_next >> 1). Both are registered on the same edge.
- full_next = (wgray_next == {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]}).
- rbin_sync = Gray-to-binary(rq2). wr_level_next = wbin_next - rbin_sync, modulo 2^(ADDR_WIDTH+1). Its range is 0..DATA_DEPTH.
- wr_overflow_next = wr_en & full. On overflow, the pointer, level and RAM contents are unchanged.
- No FSM beyond the pointer. The synchroniser output is the only source of read-side information.

## Timing
- Reset values, after one clk_0 edge with rst_0=1: wbin=0, wptr_gray=0, rq1=rq2=0, full=0, wr_level=0, wr_overflow=0, almost_full=0. waddr=0.
- Reset has priority over wr_en in the same cycle; a write requested during reset is dropped without an overflow pulse.
- Reset mid-operation discards all contents. The read side must be reset concurrently.
- Write latency: the RAM captures data at waddr on the same edge that ram_we=1. waddr advances on that edge.
- Full assertion: on the edge accepting the DATA_DEPTH-th unread entry, with no further write accepted.
- Full deassertion: a rptr_gray_async change is seen in rq2 after 2 edges. full/wr_level update on the 3rd edge.
- Full and level are pessimistic (stale read pointer) and never optimistic.
- Wrap-around: wbin goes from 2^(ADDR_WIDTH+1)-1 to 0. Gray changes exactly one bit per accepted write.
- Simultaneous write and read-pointer update: both are folded into the same next-state computation.

## Configuration
- Macro FIFO_WR_ALMOST_FULL_EN.
- Defined: almost_full is registered, with almost_full_next = (wr_level_next >= ALMOST_FULL_THRESH). It resets to 0 and follows full-flag latency.
- Undefined: almost_full is tied to 0, and no comparator is generated. ALMOST_FULL_THRESH is ignored.

## Test plan
- Reset: hold rst_0=1 for 2 edges with wr_en=1 -> waddr=0, wptr_gray=5'b00000, full=0, wr_level=0, wr_overflow=0, ram_we=0 after release with wr_en=0.
- Fill: rptr_gray_async=0, wr_en=1 for 16 cycles -> waddr steps 0..15. full=1 and wr_level=16 after the 16th edge. wptr_gray=5'b11000.
- Overflow: with full=1, wr_en=1 for one cycle -> ram_we=0, wr_overflow=1 for exactly one cycle, waddr stays 0, wptr_gray stays 5'b11000.
- Drain: from full, set rptr_gray_async=5'b00001 -> full=1 for 2 more edges, then full=0 and wr_level=15 on the 3rd edge.
- Wrap: 40 writes with rptr_gray_async tracking wptr_gray delayed 4 cycles -> full never asserts, wbin wraps 31->0, and each wptr_gray step flips exactly one bit (10000 -> 00000).
- Almost full (macro defined, THRESH=14): 13 writes give almost_full=0; the 14th edge gives almost_full=1. With the macro undefined, almost_full stays 0 throughout.
